// File: rtl/run_before_seq_pkg.sv
// run_before_seq_pkg
// Shared CAVLC definitions for the run_before sequencer: the FSM state
// encoding, default coefficient count, and the zeros_left clamp applied
// before handing a value to the run_before datapath.
package run_before_seq_pkg;

  // Largest number of coefficients in one residual block.
  localparam int RBS_MAX_COEFF = 16;

  // Width of the coefficient / symbol counters (holds 0..16).
  localparam int RBS_CNT_W = 5;

  // The run_before VLC tables only distinguish zeros_left up to 7;
  // anything above uses the ">6" table.
  localparam logic [3:0] ZL_CLAMP = 4'd7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_ISSUE = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5
  } rbs_state_t;

  // min(z, 7) narrowed to the 3-bit datapath port.
  function automatic logic [2:0] clamp_zl(input logic [3:0] z);
    return (z > ZL_CLAMP) ? ZL_CLAMP[2:0] : z[2:0];
  endfunction

endpackage

// File: rtl/run_before_seq.sv
// run_before_seq
// Walks the run_before values of one residual block in reverse-scan order
// and hands each (run_before, zeros_left) pair to an external run_before
// datapath, waiting for its finish pulse between symbols.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-low reset
//   start          one-cycle request; accepted only in IDLE
//   total_coeff    coefficient count 0..16 (latched on accepted start)
//   total_zeros    zero count 0..15 (latched on accepted start)
//   runs           packed run_before values, index 0 in the low nibble
//   rb_start       datapath start/enable, high for the whole ISSUE state
//   rb_run_before  run_before for the datapath
//   rb_zeros_left  zeros_left for the datapath, clamped to 7
//   rb_finish      datapath finish pulse, honoured only in ISSUE
//   busy           high whenever the FSM is not IDLE
//   done           one-cycle completion/abort pulse
//   err            one-cycle pulse with done when a run exceeds zeros_left
//   coded_cnt      symbols issued for the last block
module run_before_seq
  import run_before_seq_pkg::*;
#(
  parameter int MAX_COEFF = RBS_MAX_COEFF,
  parameter int RUN_W     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [4:0]                 total_coeff,
  input  logic [3:0]                 total_zeros,
  input  logic [MAX_COEFF*RUN_W-1:0] runs,
  output logic                       rb_start,
  output logic [RUN_W-1:0]           rb_run_before,
  output logic [2:0]                 rb_zeros_left,
  input  logic                       rb_finish,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [RBS_CNT_W-1:0]       coded_cnt
);

  localparam int IDX_W = $clog2(MAX_COEFF);

  rbs_state_t           state;
  rbs_state_t           next_state;
  logic [RUN_W-1:0]     runs_q [MAX_COEFF];
  logic [4:0]           tc_q;
  logic [3:0]           zl;
  logic [RBS_CNT_W-1:0] idx;
  logic [RBS_CNT_W-1:0] coded_cnt_q;
  logic                 err_q;
  logic [RUN_W-1:0]     cur_run;
  logic                 run_too_big;
  logic                 block_end;

  // idx never exceeds total_coeff-1 (<= 15), so the low bits address the table.
  assign cur_run     = runs_q[idx[IDX_W-1:0]];
  assign run_too_big = 4'(cur_run) > zl;
  // The last coefficient's run is implied, so stop once it is reached.
  assign block_end   = (zl == 4'd0) || (idx == (tc_q - 5'd1));

  // State register plus the per-block datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      tc_q        <= '0;
      zl          <= '0;
      idx         <= '0;
      coded_cnt_q <= '0;
      err_q       <= 1'b0;
      for (int i = 0; i < MAX_COEFF; i++) begin
        runs_q[i] <= '0;
      end
    end else begin
      state <= next_state;
      case (state)
        S_IDLE: begin
          if (start) begin
            tc_q        <= total_coeff;
            zl          <= total_zeros;
            idx         <= '0;
            coded_cnt_q <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < MAX_COEFF; i++) begin
              runs_q[i] <= runs[i*RUN_W +: RUN_W];
            end
          end
        end
        S_CHECK: begin
          if (run_too_big) begin
            err_q <= 1'b1;
          end
        end
        S_ISSUE: begin
          // CHECK already proved cur_run <= zl, so this cannot wrap.
          if (rb_finish) begin
            zl          <= zl - 4'(cur_run);
            idx         <= idx + 5'd1;
            coded_cnt_q <= coded_cnt_q + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_LOAD;
      S_LOAD:  next_state = ((tc_q <= 5'd1) || (zl == 4'd0)) ? S_DONE : S_CHECK;
      S_CHECK: next_state = run_too_big ? S_DONE : S_ISSUE;
      S_ISSUE: if (rb_finish) next_state = S_GAP;
      S_GAP:   next_state = block_end ? S_DONE : S_CHECK;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Outputs are decoded from the state so they stay constant for the
  // whole ISSUE state and drop to zero on the cycle reset takes effect.
  always_comb begin
    rb_start      = 1'b0;
    rb_run_before = '0;
    rb_zeros_left = '0;
    busy          = (state != S_IDLE);
    done          = (state == S_DONE);
    err           = (state == S_DONE) && err_q;
    coded_cnt     = coded_cnt_q;
    if (state == S_ISSUE) begin
      rb_start      = 1'b1;
      rb_run_before = cur_run;
      rb_zeros_left = clamp_zl(zl);
    end
  end

endmodule

// File: tb/tb_run_before_seq.sv
// tb_run_before_seq
// Self-checking bench for run_before_seq. A behavioural datapath answers
// rb_start with rb_finish after a programmable delay; expected
// (run_before, zeros_left) pairs are queued when a block is started and
// checked as each symbol is issued.
module tb_run_before_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  total_coeff;
  logic [3:0]  total_zeros;
  logic [63:0] runs;
  logic        rb_start;
  logic [3:0]  rb_run_before;
  logic [2:0]  rb_zeros_left;
  logic        rb_finish;
  logic        busy;
  logic        done;
  logic        err;
  logic [4:0]  coded_cnt;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [3:0] rb;
    logic [2:0] zl;
  } issue_t;

  issue_t exp_q[$];

  typedef struct {
    logic [4:0]  tc;
    logic [3:0]  tz;
    logic [63:0] rv;
    int          exp_cnt;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[10];

  // Datapath model controls
  int   fin_delay  = 0;
  int   dp_cnt     = 0;
  logic fin_model  = 1'b0;
  logic spur_fin   = 1'b0;
  bit   len_chk_en = 1'b1;
  int   blk_id     = 0;

  assign rb_finish = fin_model | spur_fin;

  always #5 clk = ~clk;

  run_before_seq dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .total_coeff  (total_coeff),
    .total_zeros  (total_zeros),
    .runs         (runs),
    .rb_start     (rb_start),
    .rb_run_before(rb_run_before),
    .rb_zeros_left(rb_zeros_left),
    .rb_finish    (rb_finish),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .coded_cnt    (coded_cnt)
  );

  // Behavioural run_before datapath: finish pulses fin_delay cycles after
  // rb_start is first seen.
  always @(posedge clk) begin
    if (rb_start && !fin_model) begin
      if (dp_cnt >= fin_delay) begin
        fin_model <= 1'b1;
        dp_cnt    <= 0;
      end else begin
        dp_cnt <= dp_cnt + 1;
      end
    end else begin
      fin_model <= 1'b0;
      if (!rb_start) dp_cnt <= 0;
    end
  end

  // Issue monitor: pops the scoreboard on each new symbol, checks the
  // values hold steady, the ISSUE length and the gap between symbols.
  bit         prev_start = 1'b0;
  logic [3:0] held_rb;
  logic [2:0] held_zl;
  int         hi_len = 0;
  int         lo_len = 0;
  int         fall_blk = -1;
  issue_t     exp_i;

  always @(negedge clk) begin
    if (rst && rb_start && !prev_start) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL issue_unexpected: got rb=%0d zl=%0d, expected no issue",
                 rb_run_before, rb_zeros_left);
      end else begin
        exp_i = exp_q.pop_front();
        if (rb_run_before !== exp_i.rb || rb_zeros_left !== exp_i.zl) begin
          fails++;
          $display("[TB] FAIL issue_pair: got rb=%0d zl=%0d, expected rb=%0d zl=%0d",
                   rb_run_before, rb_zeros_left, exp_i.rb, exp_i.zl);
        end
      end
      if (fall_blk == blk_id) begin
        tests++;
        if (lo_len != 2) begin
          fails++;
          $display("[TB] FAIL issue_gap: got %0d idle cycles, expected 2", lo_len);
        end
      end
      held_rb = rb_run_before;
      held_zl = rb_zeros_left;
      hi_len  = 1;
    end else if (rb_start && prev_start) begin
      tests++;
      if (rb_run_before !== held_rb || rb_zeros_left !== held_zl) begin
        fails++;
        $display("[TB] FAIL issue_stable: got rb=%0d zl=%0d, expected rb=%0d zl=%0d",
                 rb_run_before, rb_zeros_left, held_rb, held_zl);
      end
      hi_len++;
    end else if (!rb_start && prev_start) begin
      if (len_chk_en) begin
        tests++;
        if (hi_len != fin_delay + 2) begin
          fails++;
          $display("[TB] FAIL issue_len: got %0d cycles, expected %0d", hi_len, fin_delay + 2);
        end
      end
      lo_len   = 1;
      fall_blk = blk_id;
    end else begin
      lo_len++;
    end
    prev_start = rb_start;
  end

  task automatic checkOutput(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Reference behaviour of one block: the pairs the datapath should see.
  task automatic pushModel(input logic [4:0] tc, input logic [3:0] tz, input logic [63:0] rv);
    logic [3:0] z;
    logic [3:0] r;
    int         i;
    z = tz;
    i = 0;
    if (tc > 5'd1) begin
      while (z != 4'd0 && i < int'(tc) - 1) begin
        r = rv[i*4 +: 4];
        if (r > z) break;
        exp_q.push_back(issue_t'{rb: r, zl: (z > 4'd7) ? 3'd7 : z[2:0]});
        z = z - r;
        i++;
      end
    end
  endtask

  // Runs one block to completion; returns latency (start to done), err and count.
  task automatic applyStimulus(input logic [4:0] tc, input logic [3:0] tz,
                               input logic [63:0] rv, output int lat,
                               output int got_err, output int got_cnt);
    blk_id++;
    pushModel(tc, tz, rv);
    total_coeff = tc;
    total_zeros = tz;
    runs        = rv;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("done_seen", int'(done), 1);
    got_err = int'(err);
    got_cnt = int'(coded_cnt);
    checkOutput("issues_left", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    checkOutput("done_pulse", int'(done), 0);
    checkOutput("idle_busy", int'(busy), 0);
  endtask

  int lat;
  int g_err;
  int g_cnt;
  int guard;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0] = '{5'd5,  4'd3,  64'h1101,                5, 1'b0, 18};
    vecs[0].exp_cnt = 4;
    vecs[1] = '{5'd2,  4'd10, 64'hA,                   1, 1'b0, 6};
    vecs[2] = '{5'd1,  4'd5,  64'h2,                   0, 1'b0, 2};
    vecs[3] = '{5'd4,  4'd0,  64'h111,                 0, 1'b0, 2};
    vecs[4] = '{5'd3,  4'd2,  64'h3,                   0, 1'b1, 3};
    vecs[5] = '{5'd4,  4'd3,  64'h31,                  1, 1'b1, 7};
    vecs[6] = '{5'd0,  4'd0,  64'h0,                   0, 1'b0, 2};
    vecs[7] = '{5'd16, 4'd15, 64'h1111_1111_1111_1111, 15, 1'b0, 62};
    vecs[8] = '{5'd3,  4'd4,  64'h400,                 2, 1'b0, 10};
    vecs[9] = '{5'd2,  4'd15, 64'hF,                   1, 1'b0, 6};

    rst         = 1'b0;
    start       = 1'b0;
    total_coeff = '0;
    total_zeros = '0;
    runs        = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_err", int'(err), 0);
    checkOutput("rst_rb_start", int'(rb_start), 0);
    checkOutput("rst_rb_run", int'(rb_run_before), 0);
    checkOutput("rst_rb_zl", int'(rb_zeros_left), 0);
    checkOutput("rst_cnt", int'(coded_cnt), 0);
    rst = 1'b1;
    @(negedge clk);

    // Table-driven blocks with an immediate datapath
    for (int v = 0; v < 10; v++) begin
      applyStimulus(vecs[v].tc, vecs[v].tz, vecs[v].rv, lat, g_err, g_cnt);
      checkOutput($sformatf("vec%0d_cnt", v), g_cnt, vecs[v].exp_cnt);
      checkOutput($sformatf("vec%0d_err", v), g_err, int'(vecs[v].exp_err));
      checkOutput($sformatf("vec%0d_lat", v), lat, vecs[v].exp_lat);
    end

    // Slow datapath: finish 5 cycles late, ISSUE lasts 7 cycles each
    fin_delay = 5;
    applyStimulus(5'd5, 4'd3, 64'h1101, lat, g_err, g_cnt);
    checkOutput("slow_cnt", g_cnt, 4);
    checkOutput("slow_err", g_err, 0);
    checkOutput("slow_lat", lat, 38);

    // Reset while the second symbol is in ISSUE
    blk_id++;
    pushModel(5'd5, 4'd3, 64'h1101);
    total_coeff = 5'd5;
    total_zeros = 4'd3;
    runs        = 64'h1101;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!(rb_start && coded_cnt == 5'd1) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("mid_issue_reached", int'(rb_start && coded_cnt == 5'd1), 1);
    len_chk_en = 1'b0;
    rst        = 1'b0;
    @(negedge clk);
    checkOutput("midrst_rb_start", int'(rb_start), 0);
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_done", int'(done), 0);
    checkOutput("midrst_cnt", int'(coded_cnt), 0);
    checkOutput("midrst_rb_run", int'(rb_run_before), 0);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    len_chk_en = 1'b1;
    fin_delay  = 0;
    applyStimulus(5'd2, 4'd10, 64'hA, lat, g_err, g_cnt);
    checkOutput("post_rst_cnt", g_cnt, 1);
    checkOutput("post_rst_lat", lat, 6);

    // start pulsed while busy must not restart or queue a second block
    fin_delay = 5;
    blk_id++;
    pushModel(5'd2, 4'd10, 64'hA);
    total_coeff = 5'd2;
    total_zeros = 4'd10;
    runs        = 64'hA;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    total_coeff = 5'd5;
    total_zeros = 4'd3;
    runs        = 64'h1101;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!done && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("busy_start_done", int'(done), 1);
    checkOutput("busy_start_cnt", int'(coded_cnt), 1);
    checkOutput("busy_start_err", int'(err), 0);
    checkOutput("busy_start_left", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    checkOutput("busy_start_idle", int'(busy), 0);

    // rb_finish in IDLE is ignored
    spur_fin = 1'b1;
    repeat (3) @(negedge clk);
    spur_fin = 1'b0;
    checkOutput("spur_busy", int'(busy), 0);
    checkOutput("spur_cnt", int'(coded_cnt), 1);
    checkOutput("spur_rb_start", int'(rb_start), 0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/run_before_seq.md
RUN_BEFORE_SEQ -- requirements
Module: run_before_seq

Interface
REQ-001 SHALL have parameter MAX_COEFF, default 16, meaning maximum coefficients per block.
REQ-002 SHALL have parameter RUN_W, default 4, meaning width of each run_before value.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port start, input, 1, one-cycle request to encode one block's run_before symbols.
REQ-006 SHALL have port total_coeff, input, 5, coefficient count 0..16; sampled on accepted start.
REQ-007 SHALL have port total_zeros, input, 4, zero count 0..15; sampled on accepted start.
REQ-008 SHALL have port runs, input, MAX_COEFF*RUN_W, packed run_before per coefficient in reverse-scan order (index 0 in bits [3:0]); sampled on accepted start.
REQ-009 SHALL have port rb_start, output, 1, drives the run_before datapath start/enable.
REQ-010 SHALL have port rb_run_before, output, 4, run_before to the datapath.
REQ-011 SHALL have port rb_zeros_left, output, 3, zeros_left to the datapath, clamped to 7.
REQ-012 SHALL have port rb_finish, input, 1, datapath finish pulse.
REQ-013 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-014 SHALL have port done, output, 1, one-cycle pulse when a block completes or aborts.
REQ-015 SHALL have port err, output, 1, one-cycle pulse coincident with done on abort.
REQ-016 SHALL have port coded_cnt, output, 5, number of symbols issued for the last block; held until the next accepted start.

Function
REQ-017 SHALL implement states IDLE, LOAD, CHECK, ISSUE, GAP, DONE.
REQ-018 IDLE: start=1 latches inputs and sets zl=total_zeros, idx=0, coded_cnt=0 -> LOAD; start in any other state is ignored.
REQ-019 LOAD -> DONE when total_coeff<=1 or zl=0; otherwise -> CHECK.
REQ-020 CHECK: runs[idx]>zl -> DONE with err; otherwise -> ISSUE.
REQ-021 ISSUE: rb_start=1, rb_run_before=runs[idx], rb_zeros_left=min(zl,7), all held stable until rb_finish.
REQ-022 ISSUE with rb_finish=1: zl<=zl-runs[idx], idx+1, coded_cnt+1, rb_start<=0 -> GAP.
REQ-023 GAP: rb_start=0 for exactly one cycle, letting the datapath clear; then -> DONE if zl=0 or idx=total_coeff-1, else -> CHECK.
REQ-024 The last coefficient (idx=total_coeff-1) SHALL never be issued.
REQ-025 DONE: done=1 for one cycle -> IDLE.
REQ-026 Subtraction SHALL be 4-bit unsigned; CHECK guarantees it never underflows.
REQ-027 rb_finish outside ISSUE SHALL be ignored.
REQ-028 Minimum latency per symbol SHALL be CHECK+ISSUE(datapath length+2)+GAP.

Reset
REQ-029 When rst=0 at a clock edge, the block SHALL enter IDLE and clear rb_start, rb_run_before, rb_zeros_left, busy, done, err, coded_cnt, zl and idx to 0, including mid-operation, with no done pulse.

Structure
REQ-030 State encoding, MAX_COEFF and the zeros_left clamp constant (7) SHALL live in the shared CAVLC package.
REQ-031 The block SHALL be a single FSM with no sub-modules; the run_before datapath is instantiated by the parent and connected via the rb_* ports.

Verification
REQ-032 Case: total_coeff=5, total_zeros=3, runs=1,0,1,1,x -> issues (run_before,zeros_left) = (1,3),(0,2),(1,2),(1,1) -> done, coded_cnt=4, err=0.
REQ-033 Case: total_coeff=2, total_zeros=10, run0=10 -> one issue (10,7) -> done, coded_cnt=1.
REQ-034 Case: total_coeff=1 or total_zeros=0 -> no rb_start; done 2 cycles after start, coded_cnt=0.
REQ-035 Case: total_coeff=3, total_zeros=2, run0=3 -> no rb_start; done and err pulse together.
REQ-036 Case: rst=0 during ISSUE -> next cycle rb_start=0, busy=0; a new start then runs normally; start pulsed while busy -> ignored.
REQ-037 Case: rb_finish delayed 5 cycles -> rb_* stable throughout, then exactly one GAP cycle with rb_start=0.
